// File: rtl/luna_top.sv
// ----------------------------------------------------------------------------
// luna_top
// Board top level: divides the raw board clock into a pixel-enable tick,
// generates 640x480@60 VGA timing with a 12-bit RGB test pattern, and shows a
// 16-bit frame counter on the LEDs as a liveness indicator.
//
// Ports
//   raw_clk  in   1   board clock (100 MHz), the only clock in the design
//   rst      in   1   asynchronous, active-high reset
//   leds     out  16  frame counter
//   hsync    out  1   horizontal sync, active-low
//   vsync    out  1   vertical sync, active-low
//   red      out  4   red intensity
//   green    out  4   green intensity
//   blue     out  4   blue intensity
//
// All outputs come straight from flops. Sync and colour registers update only
// on the pixel tick and are computed from the pre-increment counters, so they
// trail the counters by exactly one pixel tick.
// ----------------------------------------------------------------------------
module luna_top #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        raw_clk,
    input  logic        rst,
    output logic [15:0] leds,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Counters are at least 8 bits wide so the [7:4] pattern slice always
    // exists; +1 leaves room for window ends equal to the total.
    localparam int H_W = ($clog2(H_TOTAL + 1) > 8) ? $clog2(H_TOTAL + 1) : 8;
    localparam int V_W = ($clog2(V_TOTAL + 1) > 8) ? $clog2(V_TOTAL + 1) : 8;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [H_W-1:0]   H_VIS    = H_W'(H_VISIBLE);
    localparam logic [V_W-1:0]   V_VIS    = V_W'(V_VISIBLE);
    localparam logic [H_W-1:0]   HS_START = H_W'(H_VISIBLE + H_FRONT);
    localparam logic [H_W-1:0]   HS_END   = H_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [V_W-1:0]   VS_START = V_W'(V_VISIBLE + V_FRONT);
    localparam logic [V_W-1:0]   VS_END   = V_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [H_W-1:0]   h_q, h_d;
    logic [V_W-1:0]   v_q, v_d;
    logic [15:0]      frame_q, frame_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic [3:0]       red_q, red_d;
    logic [3:0]       green_q, green_d;
    logic [3:0]       blue_q, blue_d;

    logic tick;
    logic h_last;
    logic v_last;
    logic visible;

    // With CLK_DIV=1 the divider stays at 0 and tick is permanently high.
    assign tick    = (div_q == DIV_LAST);
    assign h_last  = (h_q == H_LAST);
    assign v_last  = (v_q == V_LAST);
    assign visible = (h_q < H_VIS) && (v_q < V_VIS);

    always_comb begin
        div_d   = tick ? '0 : div_q + 1'b1;
        h_d     = h_q;
        v_d     = v_q;
        frame_d = frame_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;

        if (tick) begin
            h_d = h_last ? '0 : h_q + 1'b1;
            if (h_last) begin
                v_d = v_last ? '0 : v_q + 1'b1;
            end
            if (h_last && v_last) begin
                frame_d = frame_q + 16'd1;
            end

            // Decoded from the counters as they stand before this tick's
            // increment, giving the fixed one-tick output latency.
            hsync_d = !((h_q >= HS_START) && (h_q < HS_END));
            vsync_d = !((v_q >= VS_START) && (v_q < VS_END));
            if (visible) begin
                red_d   = h_q[7:4];
                green_d = v_q[7:4];
                blue_d  = frame_q[3:0];
            end else begin
                red_d   = 4'd0;
                green_d = 4'd0;
                blue_d  = 4'd0;
            end
        end
    end

    always_ff @(posedge raw_clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            h_q     <= '0;
            v_q     <= '0;
            frame_q <= 16'd0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            red_q   <= 4'd0;
            green_q <= 4'd0;
            blue_q  <= 4'd0;
        end else begin
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            frame_q <= frame_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

    assign leds  = frame_q;
    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign red   = red_q;
    assign green = green_q;
    assign blue  = blue_q;

endmodule

// File: tb/tb_luna_top.sv
// ----------------------------------------------------------------------------
// tb_luna_top
// Directed bench for luna_top using a shrunken raster so several whole frames
// fit in a short run. Geometry used here:
//   H: 64 visible, 8 front, 12 sync, 12 back -> 96 ticks/line, hsync h=72..83
//   V: 20 visible, 3 front, 2 sync, 5 back   -> 30 lines, vsync v=23..24
//   frame = 2880 ticks, CLK_DIV = 4 raw clocks per tick.
// Tick n (counted from reset release) lands on raw clock edge 4n and its
// outputs describe pixel h=(n-1)%96, v=(n-1)/96 of frame (n-1)/2880.
// ----------------------------------------------------------------------------
module tb_luna_top;

    localparam int CLK_DIV     = 4;
    localparam int H_VISIBLE   = 64;
    localparam int H_FRONT     = 8;
    localparam int H_SYNC      = 12;
    localparam int H_BACK      = 12;
    localparam int V_VISIBLE   = 20;
    localparam int V_FRONT     = 3;
    localparam int V_SYNC      = 2;
    localparam int V_BACK      = 5;
    localparam int H_TOTAL     = 96;
    localparam int V_TOTAL     = 30;
    localparam int FRAME_TICKS = 2880;

    logic        raw_clk = 1'b0;
    logic        rst     = 1'b0;
    logic [15:0] leds;
    logic        hsync;
    logic        vsync;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;

    int tests_run    = 0;
    int tests_failed = 0;
    int tick_n       = 0;

    luna_top #(
        .CLK_DIV  (CLK_DIV),
        .H_VISIBLE(H_VISIBLE),
        .H_FRONT  (H_FRONT),
        .H_SYNC   (H_SYNC),
        .H_BACK   (H_BACK),
        .V_VISIBLE(V_VISIBLE),
        .V_FRONT  (V_FRONT),
        .V_SYNC   (V_SYNC),
        .V_BACK   (V_BACK)
    ) dut (
        .raw_clk(raw_clk),
        .rst    (rst),
        .leds   (leds),
        .hsync  (hsync),
        .vsync  (vsync),
        .red    (red),
        .green  (green),
        .blue   (blue)
    );

    always #5 raw_clk = ~raw_clk;

    // Advance one pixel tick and sample 1 ns after the active edge.
    task automatic step_tick();
        repeat (CLK_DIV) @(posedge raw_clk);
        #1;
        tick_n++;
    endtask

    // Release on a falling edge so the next rising edge is edge 1.
    task automatic release_reset();
        @(negedge raw_clk);
        rst    = 1'b0;
        tick_n = 0;
    endtask

    task automatic test_reset();
        logic [29:0] obs;
        logic [29:0] exp;
        logic [3:0]  exp_red;
        exp = {16'h0000, 1'b1, 1'b1, 12'h000};
        // Reset rises before the first clock edge.
        #1 rst = 1'b1;
        #1;
        obs = {leds, hsync, vsync, red, green, blue};
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL reset_t0: got %h expected %h", obs, exp);
        end
        #48;
        obs = {leds, hsync, vsync, red, green, blue};
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL reset_held: got %h expected %h", obs, exp);
        end
        release_reset();
        // Ticks 1..16 show h=0..15 (all reset-like); tick 17 (edge 68)
        // shows h=16, the first pixel with red=1.
        for (int i = 1; i <= 4 * 17; i++) begin
            @(posedge raw_clk);
            #1;
            exp_red = (i >= 68) ? 4'd1 : 4'd0;
            exp = {16'h0000, 1'b1, 1'b1, exp_red, 8'h00};
            obs = {leds, hsync, vsync, red, green, blue};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL reset_release edge %0d: got %h expected %h", i, obs, exp);
            end
        end
        tick_n = 17;
        $display("[TB] test_reset done at tick %0d", tick_n);
    endtask

    task automatic test_visible_pixel();
        while (tick_n < 54) step_tick();
        // Tick 54 shows h=0x35 on line 0 of frame 0.
        tests_run++;
        if ({red, green, blue, hsync} !== {4'd3, 4'd0, 4'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL visible_h35: got r=%0d g=%0d b=%0d hs=%b expected r=3 g=0 b=0 hs=1",
                     red, green, blue, hsync);
        end
        $display("[TB] test_visible_pixel r=%0d g=%0d b=%0d", red, green, blue);
    endtask

    task automatic test_horizontal();
        int h, line;
        int first_low0 = -1;
        int first_low1 = -1;
        int low0 = 0;
        int low1 = 0;
        logic       exp_hs;
        logic [3:0] exp_red;
        while (tick_n < 1 + 2 * H_TOTAL) begin
            step_tick();
            h       = (tick_n - 1) % H_TOTAL;
            line    = (tick_n - 1) / H_TOTAL;
            exp_hs  = !((h >= 72) && (h < 84));
            exp_red = (h < 64) ? 4'(h >> 4) : 4'd0;
            tests_run++;
            if ({hsync, red, green, blue} !== {exp_hs, exp_red, 8'h00}) begin
                tests_failed++;
                $display("FAIL hline tick %0d: got hs=%b r=%0d g=%0d b=%0d expected hs=%b r=%0d g=0 b=0",
                         tick_n, hsync, red, green, blue, exp_hs, exp_red);
            end
            if (hsync === 1'b0) begin
                if (line == 0) begin
                    low0++;
                    if (first_low0 < 0) first_low0 = tick_n;
                end else begin
                    low1++;
                    if (first_low1 < 0) first_low1 = tick_n;
                end
            end
        end
        tests_run++;
        if (low0 != 12 || low1 != 12) begin
            tests_failed++;
            $display("FAIL hsync_width: got %0d/%0d ticks expected 12/12", low0, low1);
        end
        tests_run++;
        if (first_low0 != 73) begin
            tests_failed++;
            $display("FAIL hsync_start: got tick %0d expected 73", first_low0);
        end
        tests_run++;
        if (first_low1 - first_low0 != 96) begin
            tests_failed++;
            $display("FAIL line_period: got %0d expected 96", first_low1 - first_low0);
        end
        $display("[TB] test_horizontal first_low=%0d width=%0d period=%0d",
                 first_low0, low0, first_low1 - first_low0);
    endtask

    task automatic test_vertical();
        int h, v;
        int first_low = -1;
        int low_cnt = 0;
        logic       exp_vs;
        logic [3:0] exp_green;
        while (tick_n < FRAME_TICKS) begin
            step_tick();
            h         = (tick_n - 1) % H_TOTAL;
            v         = (tick_n - 1) / H_TOTAL;
            exp_vs    = !((v >= 23) && (v < 25));
            exp_green = (h < 64 && v < 20) ? 4'(v >> 4) : 4'd0;
            tests_run++;
            if ({vsync, green} !== {exp_vs, exp_green}) begin
                tests_failed++;
                $display("FAIL vframe tick %0d: got vs=%b g=%0d expected vs=%b g=%0d",
                         tick_n, vsync, green, exp_vs, exp_green);
            end
            if (vsync === 1'b0) begin
                low_cnt++;
                if (first_low < 0) first_low = tick_n;
            end
            if (tick_n == FRAME_TICKS - 1 || tick_n == FRAME_TICKS) begin
                tests_run++;
                if (leds !== ((tick_n == FRAME_TICKS) ? 16'd1 : 16'd0)) begin
                    tests_failed++;
                    $display("FAIL frame_wrap tick %0d: got leds=%0d", tick_n, leds);
                end
            end
        end
        tests_run++;
        if (low_cnt != 192) begin
            tests_failed++;
            $display("FAIL vsync_width: got %0d ticks expected 192", low_cnt);
        end
        tests_run++;
        if (first_low != 2209) begin
            tests_failed++;
            $display("FAIL vsync_start: got tick %0d expected 2209", first_low);
        end
        $display("[TB] test_vertical first_low=%0d width=%0d", first_low, low_cnt);
    endtask

    task automatic test_frame_counter();
        int h, v;
        int first_low1 = -1;
        logic [15:0] exp_leds;
        logic [3:0]  exp_blue;
        while (tick_n < 3 * FRAME_TICKS) begin
            step_tick();
            h        = (tick_n - 1) % H_TOTAL;
            v        = ((tick_n - 1) / H_TOTAL) % V_TOTAL;
            exp_leds = 16'(tick_n / FRAME_TICKS);
            exp_blue = (h < 64 && v < 20) ? 4'((tick_n - 1) / FRAME_TICKS) : 4'd0;
            tests_run++;
            if ({leds, blue} !== {exp_leds, exp_blue}) begin
                tests_failed++;
                $display("FAIL frame_cnt tick %0d: got leds=%0d b=%0d expected leds=%0d b=%0d",
                         tick_n, leds, blue, exp_leds, exp_blue);
            end
            if (vsync === 1'b0 && first_low1 < 0) first_low1 = tick_n;
        end
        tests_run++;
        if (first_low1 - 2209 != FRAME_TICKS) begin
            tests_failed++;
            $display("FAIL frame_period: got %0d expected %0d", first_low1 - 2209, FRAME_TICKS);
        end
        $display("[TB] test_frame_counter leds=%0d vsync_period=%0d", leds, first_low1 - 2209);
    endtask

    task automatic test_reset_mid_frame();
        logic [29:0] obs;
        logic [29:0] exp;
        exp = {16'h0000, 1'b1, 1'b1, 12'h000};
        // Frame 3, line 10, h=75: inside hsync, visible line, leds=3.
        while (tick_n < 3 * FRAME_TICKS + 10 * H_TOTAL + 76) step_tick();
        tests_run++;
        if ({leds, hsync} !== {16'd3, 1'b0}) begin
            tests_failed++;
            $display("FAIL pre_reset: got leds=%0d hs=%b expected leds=3 hs=0", leds, hsync);
        end
        @(posedge raw_clk);
        #3 rst = 1'b1;
        #1;
        obs = {leds, hsync, vsync, red, green, blue};
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL reset_async: got %h expected %h", obs, exp);
        end
        #46;
        release_reset();
        while (tick_n < 72) step_tick();
        tests_run++;
        if (hsync !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart_hs72: got %b expected 1", hsync);
        end
        step_tick();
        tests_run++;
        if (hsync !== 1'b0) begin
            tests_failed++;
            $display("FAIL restart_hs73: got %b expected 0", hsync);
        end
        tests_run++;
        if (leds !== 16'd0) begin
            tests_failed++;
            $display("FAIL restart_leds: got %0d expected 0", leds);
        end
        $display("[TB] test_reset_mid_frame hsync at tick 73 = %b", hsync);
    endtask

    initial begin
        test_reset();
        test_visible_pixel();
        test_horizontal();
        test_vertical();
        test_frame_counter();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
